// File: rtl/hilo_if.sv
// EX-stage HI/LO bus: multiplier handshake, move-to/from requests and architectural results.
interface hilo_if;
  logic        mul_issue;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic [1:0]  rd_sel;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic        mul_start;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_err;

  modport master (
    output mul_issue, prod_in, prod_valid, rd_sel, wr_sel, wr_data,
    input  mul_start, stall, rd_data, hi, lo, mul_err
  );

  modport slave (
    input  mul_issue, prod_in, prod_valid, rd_sel, wr_sel, wr_data,
    output mul_start, stall, rd_data, hi, lo, mul_err
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register file: captures multiplier products, services MFHI/MFLO/MTHI/MTLO,
// stalls requests while a multiply is in flight and aborts a multiply that never completes.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 48
) (
  input  logic   clk,
  input  logic   rst_n,
  hilo_if.slave  bus
);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned DW    = 32;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_hi;
  logic [DW-1:0]    r_lo;
  logic             r_err;

  logic             w_idle;
  logic             w_req;
  logic [DW-1:0]    w_rd;

  assign w_idle = (r_state == IDLE);
  assign w_req  = bus.mul_issue
                | (bus.rd_sel == 2'b01) | (bus.rd_sel == 2'b10)
                | (bus.wr_sel == 2'b01) | (bus.wr_sel == 2'b10);

  // State, counter and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.wr_sel == 2'b01) r_hi <= bus.wr_data;
          if (bus.wr_sel == 2'b10) r_lo <= bus.wr_data;
          if (bus.mul_issue) begin
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.prod_valid) begin
            r_hi    <= bus.prod_in[63:32];
            r_lo    <= bus.prod_in[31:0];
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read mux; reads only return data when no multiply is pending.
  always_comb begin
    w_rd = '0;
    if (w_idle && rst_n) begin
      if (bus.rd_sel == 2'b01) w_rd = r_hi;
      if (bus.rd_sel == 2'b10) w_rd = r_lo;
    end
  end

  // Reset gating keeps the combinational outputs low while reset is held.
  assign bus.mul_start = rst_n & w_idle & bus.mul_issue;
  assign bus.stall     = rst_n & ~w_idle & w_req;
  assign bus.rd_data   = w_rd;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.mul_err   = r_err;
endmodule
